pipeline_hazard_ctrl: RTL and testbench

Parametrised successor to the 5-stage pipeline hazard unit. It resolves load-use, branch/jump, icache-miss and dcache-miss hazards, and generates per-stage stall/flush, PC enable and EX operand-forwarding selects. A small FSM tracks dcache waits and halt. It adds a dcache-wait watchdog and a stall performance counter. It sits beside the datapath, fed from the IF/ID, ID/EX, EX/MEM and MEM/WB latches.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 21 ++
 rtl/pipeline_hazard_ctrl_fwd_unit.sv | 39 +++
 rtl/pipeline_hazard_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and
// EX operand forwarding selects.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZU_RUN      = 2'b00,
    HZU_MEM_WAIT = 2'b01,
    HZU_HALTED   = 2'b10
  } hzu_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_MEM_WAIT = 2'b01;
  localparam logic [1:0] ST_HALTED   = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Combinational EX operand forwarding select for one source register;
// the younger EX/MEM result takes precedence over MEM/WB.
module pipeline_hazard_ctrl_fwd_unit
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W  = 5,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic             exmem_regwen,
  input  logic [REG_W-1:0] memwb_rd,
  input  logic             memwb_regwen,
  output logic [1:0]       sel
);

  localparam logic [REG_W-1:0] R0 = {REG_W{1'b0}};

  logic mem_hit_s;
  logic wb_hit_s;

  assign mem_hit_s = exmem_regwen && (exmem_rd != R0) && (exmem_rd == src);
  assign wb_hit_s  = memwb_regwen && (memwb_rd != R0) && (memwb_rd == src);

  // select the forwarding source, or the register file when forwarding is disabled
  always_comb begin
    sel = FWD_RF;
    if (!FWD_EN) begin
      sel = FWD_RF;
    end else if (mem_hit_s) begin
      sel = FWD_MEM;
    end else if (wb_hit_s) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard controller: stall/flush/PC enable, forwarding
// selects, dcache-wait/halt FSM, dcache-wait watchdog and stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W       = 5,
  parameter bit          FWD_EN      = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_use_rs,
  input  logic             ifid_use_rt,
  input  logic [REG_W-1:0] idex_rs,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             idex_regwen,
  input  logic             idex_memren,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic             exmem_regwen,
  input  logic             exmem_memren,
  input  logic             exmem_memwen,
  input  logic [REG_W-1:0] memwb_rd,
  input  logic             memwb_regwen,
  input  logic             jump,
  input  logic             branch_taken,
  input  logic             halt,
  output logic             pc_en,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_exmem,
  output logic             stall_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             flush_memwb,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned      WD_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(MEM_TIMEOUT);
  localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
  localparam logic [WD_W-1:0]  WD_ZERO = WD_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [REG_W-1:0] R0      = {REG_W{1'b0}};

  logic             dmiss_s;
  logic             lu_s;
  logic [1:0]       fwd_a_s;
  logic [1:0]       fwd_b_s;
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WD_W-1:0]  wd_cnt_r;
  logic [WD_W-1:0]  wd_cnt_nxt_s;
  logic             mem_timeout_r;
  logic [CNT_W-1:0] stall_cycles_r;

  // true when a producer (rd, wen) feeds a source the ID instruction reads
  function automatic logic id_reads(input logic [REG_W-1:0] rd, input logic wen,
                                    input logic [REG_W-1:0] rs, input logic use_rs,
                                    input logic [REG_W-1:0] rt, input logic use_rt);
    return wen && (rd != R0) && ((use_rs && (rs == rd)) || (use_rt && (rt == rd)));
  endfunction

  assign dmiss_s = (exmem_memren | exmem_memwen) & ~dhit;

  // without forwarding every in-flight RAW producer must drain before ID proceeds
  assign lu_s = (idex_memren & id_reads(idex_rd, idex_regwen, ifid_rs, ifid_use_rs, ifid_rt, ifid_use_rt))
              | (!FWD_EN & (id_reads(idex_rd, idex_regwen, ifid_rs, ifid_use_rs, ifid_rt, ifid_use_rt)
                          | id_reads(exmem_rd, exmem_regwen, ifid_rs, ifid_use_rs, ifid_rt, ifid_use_rt)));

  pipeline_hazard_ctrl_fwd_unit #(.REG_W(REG_W), .FWD_EN(FWD_EN)) u_fwd_a (
    .src(idex_rs), .exmem_rd(exmem_rd), .exmem_regwen(exmem_regwen),
    .memwb_rd(memwb_rd), .memwb_regwen(memwb_regwen), .sel(fwd_a_s)
  );

  pipeline_hazard_ctrl_fwd_unit #(.REG_W(REG_W), .FWD_EN(FWD_EN)) u_fwd_b (
    .src(idex_rt), .exmem_rd(exmem_rd), .exmem_regwen(exmem_regwen),
    .memwb_rd(memwb_rd), .memwb_regwen(memwb_regwen), .sel(fwd_b_s)
  );

  // prioritised stall/flush/PC-enable decode
  always_comb begin
    pc_en       = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    stall_memwb = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    flush_memwb = 1'b0;
    fwd_a       = nRST ? FWD_RF : fwd_a_s;
    fwd_b       = nRST ? FWD_RF : fwd_b_s;
    if (nRST) begin
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
      flush_memwb = 1'b1;
    end else if (state_r == ST_HALTED) begin
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      stall_exmem = 1'b1;
      stall_memwb = 1'b1;
    end else if (dmiss_s) begin
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      stall_exmem = 1'b1;
      flush_memwb = 1'b1;
    end else if (branch_taken) begin
      // ID and the load-use/jump it may carry are wrong-path
      pc_en      = 1'b1;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (lu_s) begin
      stall_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (jump) begin
      pc_en      = 1'b1;
      flush_ifid = 1'b1;
    end else if (!ihit) begin
      flush_ifid = 1'b1;
    end else begin
      pc_en = 1'b1;
    end
  end

  // next FSM state and watchdog count; a miss completes before halt is honoured
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (halt && !dmiss_s)  state_nxt_s = ST_HALTED;
        else if (dmiss_s)      state_nxt_s = ST_MEM_WAIT;
        else                   state_nxt_s = ST_RUN;
      end
      ST_MEM_WAIT: begin
        if (halt && !dmiss_s)  state_nxt_s = ST_HALTED;
        else if (dhit)         state_nxt_s = ST_RUN;
        else                   state_nxt_s = ST_MEM_WAIT;
      end
      ST_HALTED:               state_nxt_s = ST_HALTED;
      default:                 state_nxt_s = ST_RUN;
    endcase
    if (state_nxt_s != ST_MEM_WAIT) begin
      wd_cnt_nxt_s = WD_ZERO;
    end else if (wd_cnt_r == WD_MAX) begin
      wd_cnt_nxt_s = WD_MAX;
    end else begin
      wd_cnt_nxt_s = wd_cnt_r + WD_ONE;
    end
  end

  // FSM, watchdog and stall counter registers
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_r        <= ST_RUN;
      wd_cnt_r       <= WD_ZERO;
      mem_timeout_r  <= 1'b0;
      stall_cycles_r <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      wd_cnt_r <= wd_cnt_nxt_s;
      if (wd_cnt_nxt_s == WD_MAX) mem_timeout_r <= 1'b1;
      if (!pc_en && (state_r != ST_HALTED)) stall_cycles_r <= stall_cycles_r + CNT_ONE;
    end
  end

  assign state        = state_r;
  assign mem_timeout  = mem_timeout_r;
  assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed table-driven bench for pipeline_hazard_ctrl, with a forwarding
// instance and a no-forwarding instance driven by the same stimulus.
module tb_pipeline_hazard_ctrl;

  logic CLK = 1'b0;
  logic nRST = 1'b1;
  logic ihit, dhit, jump, branch_taken, halt;
  logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
  logic ifid_use_rs, ifid_use_rt, idex_regwen, idex_memren;
  logic exmem_regwen, exmem_memren, exmem_memwen, memwb_regwen;

  logic pc_en, stall_ifid, stall_idex, stall_exmem, stall_memwb;
  logic flush_ifid, flush_idex, flush_exmem, flush_memwb, mem_timeout;
  logic [1:0] fwd_a, fwd_b, state;
  logic [15:0] stall_cycles;

  logic nf_pc_en, nf_stall_ifid, nf_stall_idex, nf_stall_exmem, nf_stall_memwb;
  logic nf_flush_ifid, nf_flush_idex, nf_flush_exmem, nf_flush_memwb, nf_mem_timeout;
  logic [1:0] nf_fwd_a, nf_fwd_b, nf_state;
  logic [15:0] nf_stall_cycles;

  logic [3:0] stall_v, flush_v, nf_stall_v, nf_flush_v;
  assign stall_v    = {stall_ifid, stall_idex, stall_exmem, stall_memwb};
  assign flush_v    = {flush_ifid, flush_idex, flush_exmem, flush_memwb};
  assign nf_stall_v = {nf_stall_ifid, nf_stall_idex, nf_stall_exmem, nf_stall_memwb};
  assign nf_flush_v = {nf_flush_ifid, nf_flush_idex, nf_flush_exmem, nf_flush_memwb};

  pipeline_hazard_ctrl #(.REG_W(5), .FWD_EN(1'b1), .MEM_TIMEOUT(2), .CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_regwen(idex_regwen), .idex_memren(idex_memren),
    .exmem_rd(exmem_rd), .exmem_regwen(exmem_regwen), .exmem_memren(exmem_memren),
    .exmem_memwen(exmem_memwen), .memwb_rd(memwb_rd), .memwb_regwen(memwb_regwen),
    .jump(jump), .branch_taken(branch_taken), .halt(halt),
    .pc_en(pc_en), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .stall_memwb(stall_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .flush_memwb(flush_memwb),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  pipeline_hazard_ctrl #(.REG_W(5), .FWD_EN(1'b0), .MEM_TIMEOUT(2), .CNT_W(16)) dut_nf (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_regwen(idex_regwen), .idex_memren(idex_memren),
    .exmem_rd(exmem_rd), .exmem_regwen(exmem_regwen), .exmem_memren(exmem_memren),
    .exmem_memwen(exmem_memwen), .memwb_rd(memwb_rd), .memwb_regwen(memwb_regwen),
    .jump(jump), .branch_taken(branch_taken), .halt(halt),
    .pc_en(nf_pc_en), .stall_ifid(nf_stall_ifid), .stall_idex(nf_stall_idex),
    .stall_exmem(nf_stall_exmem), .stall_memwb(nf_stall_memwb),
    .flush_ifid(nf_flush_ifid), .flush_idex(nf_flush_idex),
    .flush_exmem(nf_flush_exmem), .flush_memwb(nf_flush_memwb),
    .fwd_a(nf_fwd_a), .fwd_b(nf_fwd_b), .state(nf_state),
    .mem_timeout(nf_mem_timeout), .stall_cycles(nf_stall_cycles)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic ihit, dhit, jump, br;
    logic [4:0] ifid_rs, ifid_rt;
    logic use_rs, use_rt;
    logic [4:0] idex_rs, idex_rt, idex_rd;
    logic idex_regwen, idex_memren;
    logic [4:0] exmem_rd;
    logic exmem_regwen;
    logic [4:0] memwb_rd;
    logic memwb_regwen;
    logic e_pc_en;
    logic [3:0] e_stall, e_flush;
    logic [1:0] e_fwd_a, e_fwd_b;
    logic e_nf_pc_en, e_nf_stall_ifid;
    logic [1:0] e_nf_fwd_a;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];
  int n_tot = 0;
  int n_bad = 0;
  logic [15:0] sc_exp = 16'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b1; jump = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_use_rs = 1'b0; ifid_use_rt = 1'b0;
    idex_rs = 5'd0; idex_rt = 5'd0; idex_rd = 5'd0; idex_regwen = 1'b0; idex_memren = 1'b0;
    exmem_rd = 5'd0; exmem_regwen = 1'b0; exmem_memren = 1'b0; exmem_memwen = 1'b0;
    memwb_rd = 5'd0; memwb_regwen = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    ihit = v.ihit; dhit = v.dhit; jump = v.jump; branch_taken = v.br; halt = 1'b0;
    ifid_rs = v.ifid_rs; ifid_rt = v.ifid_rt; ifid_use_rs = v.use_rs; ifid_use_rt = v.use_rt;
    idex_rs = v.idex_rs; idex_rt = v.idex_rt; idex_rd = v.idex_rd;
    idex_regwen = v.idex_regwen; idex_memren = v.idex_memren;
    exmem_rd = v.exmem_rd; exmem_regwen = v.exmem_regwen; exmem_memren = 1'b0; exmem_memwen = 1'b0;
    memwb_rd = v.memwb_rd; memwb_regwen = v.memwb_regwen;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_pc_en"}, 32'(pc_en), 32'd0);
    chk({tag, "_stall"}, 32'(stall_v), 32'h0);
    chk({tag, "_flush"}, 32'(flush_v), 32'hF);
    chk({tag, "_fwd_a"}, 32'(fwd_a), 32'd0);
    chk({tag, "_fwd_b"}, 32'(fwd_b), 32'd0);
    chk({tag, "_mem_timeout"}, 32'(mem_timeout), 32'd0);
    chk({tag, "_stall_cycles"}, 32'(stall_cycles), 32'd0);
  endtask

  initial begin
    //            ih dh j br rs rt urs urt exrs exrt exrd exwen exmr mrd mwen wbrd wbwen | pc stall   flush   fa     fb     nfpc nfst nffa
    vecs[0]  = '{1,1,0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 0,0, 1,4'b0000,4'b0000,2'b00,2'b00, 1,0,2'b00};
    vecs[1]  = '{1,1,0,0, 8,0,1,0, 0,0,8,1,1, 0,0, 0,0, 0,4'b1000,4'b0100,2'b00,2'b00, 0,1,2'b00};
    vecs[2]  = '{1,1,0,0, 8,0,1,0, 0,0,0,1,1, 0,0, 0,0, 1,4'b0000,4'b0000,2'b00,2'b00, 1,0,2'b00};
    vecs[3]  = '{1,1,0,1, 8,0,1,0, 0,0,8,1,1, 0,0, 0,0, 1,4'b0000,4'b1100,2'b00,2'b00, 1,0,2'b00};
    vecs[4]  = '{1,1,1,0, 8,0,1,0, 0,0,8,1,1, 0,0, 0,0, 0,4'b1000,4'b0100,2'b00,2'b00, 0,1,2'b00};
    vecs[5]  = '{1,1,1,0, 0,0,0,0, 0,0,0,0,0, 0,0, 0,0, 1,4'b0000,4'b1000,2'b00,2'b00, 1,0,2'b00};
    vecs[6]  = '{0,1,0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 0,0, 0,4'b0000,4'b1000,2'b00,2'b00, 0,0,2'b00};
    vecs[7]  = '{1,1,0,0, 5,0,1,0, 5,0,0,0,0, 5,1, 5,1, 1,4'b0000,4'b0000,2'b10,2'b00, 0,1,2'b00};
    vecs[8]  = '{1,1,0,0, 5,0,1,0, 5,0,0,0,0, 5,0, 5,1, 1,4'b0000,4'b0000,2'b01,2'b00, 1,0,2'b00};
    vecs[9]  = '{1,1,0,0, 0,0,0,0, 3,7,0,0,0, 7,1, 7,1, 1,4'b0000,4'b0000,2'b00,2'b10, 1,0,2'b00};
    vecs[10] = '{1,1,0,0, 0,0,0,0, 6,7,0,0,0, 6,1, 7,1, 1,4'b0000,4'b0000,2'b10,2'b01, 1,0,2'b00};
    vecs[11] = '{1,1,0,0, 0,0,1,0, 0,0,0,0,0, 0,1, 0,1, 1,4'b0000,4'b0000,2'b00,2'b00, 1,0,2'b00};
    vecs[12] = '{1,1,0,0, 0,9,0,1, 0,0,9,1,0, 0,0, 0,0, 1,4'b0000,4'b0000,2'b00,2'b00, 0,1,2'b00};
    vecs[13] = '{0,1,0,0, 8,0,1,0, 0,0,8,1,1, 0,0, 0,0, 0,4'b1000,4'b0100,2'b00,2'b00, 0,1,2'b00};

    // reset values, with forwarding-eligible inputs present
    idle();
    idex_rs = 5'd5; exmem_rd = 5'd5; exmem_regwen = 1'b1;
    #12;
    chk_reset_outputs("rst");
    chk("rst_nf_stall", 32'(nf_stall_v), 32'h0);
    chk("rst_nf_flush", 32'(nf_flush_v), 32'hF);
    chk("rst_nf_pc_en", 32'(nf_pc_en), 32'd0);
    chk("rst_nf_fwd", 32'({nf_fwd_a, nf_fwd_b}), 32'd0);
    chk("rst_nf_state", 32'(nf_state), 32'd0);
    chk("rst_nf_misc", 32'({nf_mem_timeout, nf_stall_cycles}), 32'd0);
    @(negedge CLK);
    idle();
    nRST = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      apply(vecs[i]);
      #1;
      chk($sformatf("v%0d_pc_en", i), 32'(pc_en), 32'(vecs[i].e_pc_en));
      chk($sformatf("v%0d_stall", i), 32'(stall_v), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_flush", i), 32'(flush_v), 32'(vecs[i].e_flush));
      chk($sformatf("v%0d_fwd_a", i), 32'(fwd_a), 32'(vecs[i].e_fwd_a));
      chk($sformatf("v%0d_fwd_b", i), 32'(fwd_b), 32'(vecs[i].e_fwd_b));
      chk($sformatf("v%0d_nf_pc_en", i), 32'(nf_pc_en), 32'(vecs[i].e_nf_pc_en));
      chk($sformatf("v%0d_nf_stall_ifid", i), 32'(nf_stall_ifid), 32'(vecs[i].e_nf_stall_ifid));
      chk($sformatf("v%0d_nf_fwd_a", i), 32'(nf_fwd_a), 32'(vecs[i].e_nf_fwd_a));
      chk($sformatf("v%0d_state", i), 32'(state), 32'd0);
      if (!vecs[i].e_pc_en) sc_exp = sc_exp + 16'd1;
    end
    @(negedge CLK);
    idle();
    #1;
    chk("table_stall_cycles", 32'(stall_cycles), 32'(sc_exp));

    // dcache miss held 3 cycles, watchdog at 2
    @(negedge CLK);
    exmem_memren = 1'b1; dhit = 1'b0;
    #1;
    chk("miss0_state", 32'(state), 32'd0);
    chk("miss0_pc_en", 32'(pc_en), 32'd0);
    chk("miss0_stall", 32'(stall_v), 32'hE);
    chk("miss0_flush", 32'(flush_v), 32'h1);
    sc_exp = sc_exp + 16'd1;
    @(negedge CLK); #1;
    chk("miss1_state", 32'(state), 32'd1);
    chk("miss1_timeout", 32'(mem_timeout), 32'd0);
    sc_exp = sc_exp + 16'd1;
    @(negedge CLK); #1;
    chk("miss2_state", 32'(state), 32'd1);
    chk("miss2_timeout", 32'(mem_timeout), 32'd1);
    sc_exp = sc_exp + 16'd1;
    @(negedge CLK);
    dhit = 1'b1;
    #1;
    chk("miss3_state", 32'(state), 32'd1);
    chk("miss3_pc_en", 32'(pc_en), 32'd1);
    @(negedge CLK);
    idle();
    #1;
    chk("miss4_state", 32'(state), 32'd0);
    chk("miss4_timeout_sticky", 32'(mem_timeout), 32'd1);
    chk("miss4_stall_cycles", 32'(stall_cycles), 32'(sc_exp));

    // halt raised during a miss: the miss completes first
    @(negedge CLK);
    exmem_memren = 1'b1; dhit = 1'b0; halt = 1'b1;
    #1;
    chk("halt0_state", 32'(state), 32'd0);
    sc_exp = sc_exp + 16'd1;
    @(negedge CLK); #1;
    chk("halt1_state", 32'(state), 32'd1);
    sc_exp = sc_exp + 16'd1;
    @(negedge CLK);
    dhit = 1'b1;
    #1;
    chk("halt2_state", 32'(state), 32'd1);
    @(negedge CLK);
    exmem_memren = 1'b0; halt = 1'b0; branch_taken = 1'b1;
    #1;
    chk("halt3_state", 32'(state), 32'd2);
    chk("halt3_pc_en", 32'(pc_en), 32'd0);
    chk("halt3_stall", 32'(stall_v), 32'hF);
    chk("halt3_flush", 32'(flush_v), 32'h0);
    @(negedge CLK);
    ihit = 1'b0; jump = 1'b1;
    #1;
    chk("halt4_state", 32'(state), 32'd2);
    chk("halt4_stall_cycles", 32'(stall_cycles), 32'(sc_exp));

    // asynchronous reset in the middle of a dcache wait
    @(negedge CLK);
    idle();
    nRST = 1'b1;
    #2;
    nRST = 1'b0;
    @(negedge CLK);
    exmem_memren = 1'b1; dhit = 1'b0;
    @(negedge CLK); #1;
    chk("arst_pre_state", 32'(state), 32'd1);
    @(negedge CLK); #1;
    chk("arst_pre_timeout", 32'(mem_timeout), 32'd1);
    idex_rs = 5'd5; exmem_rd = 5'd5; exmem_regwen = 1'b1;
    #2;
    nRST = 1'b1;
    #1;
    chk_reset_outputs("arst");
    @(negedge CLK);
    idle();
    nRST = 1'b0;
    #1;
    chk("arst_rel_state", 32'(state), 32'd0);
    chk("arst_rel_pc_en", 32'(pc_en), 32'd1);
    @(negedge CLK); #1;
    chk("arst_post_state", 32'(state), 32'd0);
    chk("arst_post_cnt", 32'({mem_timeout, stall_cycles}), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
